// File: rtl/env_ctrl_pkg.sv
// Shared types for the envelope note controller: FSM states, preset field
// indices and the envelope shape record.
package env_ctrl_pkg;

  localparam int VAL_W_DEF  = 18;
  localparam int TICK_W_DEF = 32;
  localparam int KEY_W_DEF  = 7;

  localparam logic [2:0] FLD_A = 3'd0;
  localparam logic [2:0] FLD_B = 3'd1;
  localparam logic [2:0] FLD_C = 3'd2;
  localparam logic [2:0] FLD_D = 3'd3;
  localparam logic [2:0] FLD_X = 3'd4;
  localparam logic [2:0] FLD_Y = 3'd5;
  localparam logic [2:0] FLD_Z = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_HELD,
    ST_STOP,
    ST_REL
  } state_t;

  typedef struct packed {
    logic [VAL_W_DEF-1:0]  a;
    logic [VAL_W_DEF-1:0]  b;
    logic [VAL_W_DEF-1:0]  c;
    logic [VAL_W_DEF-1:0]  d;
    logic [TICK_W_DEF-1:0] x;
    logic [TICK_W_DEF-1:0] y;
    logic [TICK_W_DEF-1:0] z;
  } shape_t;

endpackage

// File: rtl/env_preset_table.sv
// Writable table of envelope shapes: one field-addressed write port and one
// combinational read port returning a whole shape.
module env_preset_table
  import env_ctrl_pkg::*;
#(
  parameter int VAL_W   = VAL_W_DEF,
  parameter int TICK_W  = TICK_W_DEF,
  parameter int NPRESET = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(NPRESET)-1:0] waddr,
  input  logic [2:0]                 field,
  input  logic [TICK_W-1:0]          wdata,
  input  logic [$clog2(NPRESET)-1:0] raddr,
  output logic [VAL_W-1:0]           rd_a,
  output logic [VAL_W-1:0]           rd_b,
  output logic [VAL_W-1:0]           rd_c,
  output logic [VAL_W-1:0]           rd_d,
  output logic [TICK_W-1:0]          rd_x,
  output logic [TICK_W-1:0]          rd_y,
  output logic [TICK_W-1:0]          rd_z
);

  logic [VAL_W-1:0]  a_q [NPRESET];
  logic [VAL_W-1:0]  b_q [NPRESET];
  logic [VAL_W-1:0]  c_q [NPRESET];
  logic [VAL_W-1:0]  d_q [NPRESET];
  logic [TICK_W-1:0] x_q [NPRESET];
  logic [TICK_W-1:0] y_q [NPRESET];
  logic [TICK_W-1:0] z_q [NPRESET];

  // Level fields keep only the low VAL_W bits of the write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPRESET; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
        d_q[i] <= '0;
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
    end else if (we) begin
      case (field)
        FLD_A:   a_q[waddr] <= wdata[VAL_W-1:0];
        FLD_B:   b_q[waddr] <= wdata[VAL_W-1:0];
        FLD_C:   c_q[waddr] <= wdata[VAL_W-1:0];
        FLD_D:   d_q[waddr] <= wdata[VAL_W-1:0];
        FLD_X:   x_q[waddr] <= wdata;
        FLD_Y:   y_q[waddr] <= wdata;
        FLD_Z:   z_q[waddr] <= wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_a = a_q[raddr];
    rd_b = b_q[raddr];
    rd_c = c_q[raddr];
    rd_d = d_q[raddr];
    rd_x = x_q[raddr];
    rd_y = y_q[raddr];
    rd_z = z_q[raddr];
  end

endmodule

// File: rtl/envelope_note_controller.sv
// Key-event front end for the envelope generator: last-note priority voice
// control with a one-deep pending press and a frozen shape per note.
module envelope_note_controller
  import env_ctrl_pkg::*;
#(
  parameter int VAL_W   = VAL_W_DEF,
  parameter int TICK_W  = TICK_W_DEF,
  parameter int KEY_W   = KEY_W_DEF,
  parameter int NPRESET = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_valid,
  output logic                       key_ready,
  input  logic                       key_down,
  input  logic [KEY_W-1:0]           key_code,
  input  logic [$clog2(NPRESET)-1:0] key_preset,
  input  logic                       cfg_we,
  input  logic [$clog2(NPRESET)-1:0] cfg_addr,
  input  logic [2:0]                 cfg_field,
  input  logic [TICK_W-1:0]          cfg_data,
  output logic                       note_on,
  output logic                       note_off,
  output logic [VAL_W-1:0]           env_a,
  output logic [VAL_W-1:0]           env_b,
  output logic [VAL_W-1:0]           env_c,
  output logic [VAL_W-1:0]           env_d,
  output logic [TICK_W-1:0]          env_x,
  output logic [TICK_W-1:0]          env_y,
  output logic [TICK_W-1:0]          env_z,
  input  logic                       env_busy,
  input  logic                       env_done,
  output logic [KEY_W-1:0]           active_key,
  output logic                       voice_busy
);

  localparam int PW = $clog2(NPRESET);

  state_t           state;
  logic             rel_seen;
  logic             pend_valid;
  logic [KEY_W-1:0] pend_key;
  logic [PW-1:0]    pend_preset;

  logic             pend_valid_nxt;
  logic [KEY_W-1:0] pend_key_nxt;
  logic [PW-1:0]    pend_preset_nxt;

  logic             accept;
  logic             press;
  logic             rel_act;
  logic             rel_pend;
  logic [PW-1:0]    rd_addr;

  logic [VAL_W-1:0]  rd_a, rd_b, rd_c, rd_d;
  logic [TICK_W-1:0] rd_x, rd_y, rd_z;

  env_preset_table #(
    .VAL_W   (VAL_W),
    .TICK_W  (TICK_W),
    .NPRESET (NPRESET)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .field (cfg_field),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rd_a  (rd_a),
    .rd_b  (rd_b),
    .rd_c  (rd_c),
    .rd_d  (rd_d),
    .rd_x  (rd_x),
    .rd_y  (rd_y),
    .rd_z  (rd_z)
  );

  // A press cannot be taken in the very cycle the full slot is handed to the voice.
  always_comb begin
    key_ready = !((state == ST_REL) && env_done && pend_valid && key_down);
    accept    = key_valid && key_ready;
    press     = accept && key_down;
    rel_act   = accept && !key_down && (key_code == active_key);
    rel_pend  = accept && !key_down && pend_valid && (key_code == pend_key);

    pend_valid_nxt  = pend_valid;
    pend_key_nxt    = pend_key;
    pend_preset_nxt = pend_preset;
    if (state != ST_IDLE) begin
      if (press) begin
        pend_valid_nxt  = 1'b1;
        pend_key_nxt    = key_code;
        pend_preset_nxt = key_preset;
      end else if (rel_pend) begin
        pend_valid_nxt = 1'b0;
      end
    end

    rd_addr    = (state == ST_REL) ? pend_preset_nxt : key_preset;
    voice_busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      rel_seen    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_key    <= '0;
      pend_preset <= '0;
      active_key  <= '0;
      env_a       <= '0;
      env_b       <= '0;
      env_c       <= '0;
      env_d       <= '0;
      env_x       <= '0;
      env_y       <= '0;
      env_z       <= '0;
    end else begin
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      pend_valid  <= pend_valid_nxt;
      pend_key    <= pend_key_nxt;
      pend_preset <= pend_preset_nxt;
      case (state)
        ST_IDLE: begin
          if (press) begin
            env_a      <= rd_a;
            env_b      <= rd_b;
            env_c      <= rd_c;
            env_d      <= rd_d;
            env_x      <= rd_x;
            env_y      <= rd_y;
            env_z      <= rd_z;
            active_key <= key_code;
            rel_seen   <= 1'b0;
            note_on    <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (rel_act) rel_seen <= 1'b1;
          state <= ST_ARM;
        end
        ST_ARM: begin
          if (rel_act) rel_seen <= 1'b1;
          if (env_busy) state <= ST_HELD;
        end
        // An early release or a queued press ends the note as soon as it is held.
        ST_HELD: begin
          if (rel_seen || pend_valid || press || rel_act) begin
            rel_seen <= 1'b0;
            note_off <= 1'b1;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          state <= ST_REL;
        end
        ST_REL: begin
          if (env_done) begin
            if (pend_valid_nxt) begin
              env_a      <= rd_a;
              env_b      <= rd_b;
              env_c      <= rd_c;
              env_d      <= rd_d;
              env_x      <= rd_x;
              env_y      <= rd_y;
              env_z      <= rd_z;
              active_key <= pend_key_nxt;
              pend_valid <= 1'b0;
              rel_seen   <= 1'b0;
              note_on    <= 1'b1;
              state      <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_envelope_note_controller.sv
// Bench for envelope_note_controller: directed note scenarios followed by
// random key/envelope traffic, all checked against a voice-lifecycle model.
module tb_envelope_note_controller;
  import env_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, key_valid, key_down, cfg_we, env_busy, env_done;
  logic [6:0]  key_code;
  logic [1:0]  key_preset, cfg_addr;
  logic [2:0]  cfg_field;
  logic [31:0] cfg_data;
  logic        key_ready, note_on, note_off, voice_busy;
  logic [17:0] env_a, env_b, env_c, env_d;
  logic [31:0] env_x, env_y, env_z;
  logic [6:0]  active_key;

  always #5 clk = ~clk;

  envelope_note_controller dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_down(key_down), .key_code(key_code), .key_preset(key_preset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .note_on(note_on), .note_off(note_off),
    .env_a(env_a), .env_b(env_b), .env_c(env_c), .env_d(env_d),
    .env_x(env_x), .env_y(env_y), .env_z(env_z),
    .env_busy(env_busy), .env_done(env_done),
    .active_key(active_key), .voice_busy(voice_busy)
  );

  int total = 0;
  int bad   = 0;

  // Voice lifecycle phases of the reference model.
  localparam int SILENT = 0, LAUNCH = 1, ENGAGE = 2, SOUND = 3, RELEASE = 4, DECAY = 5;

  shape_t     m_tbl [4];
  shape_t     m_cur;
  logic [6:0] m_key;
  int         m_ph;
  bit         m_early;
  bit         m_pv;
  logic [6:0] m_pk;
  logic [1:0] m_pp;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_tbl[i] = '0;
    m_cur = '0; m_key = '0; m_ph = SILENT; m_early = 0; m_pv = 0; m_pk = '0; m_pp = '0;
  endtask

  function automatic bit m_ready();
    return !(m_ph == DECAY && env_done && m_pv && key_down);
  endfunction

  // Advance the model by one clock using the inputs held across the edge.
  task automatic m_step();
    bit acc, prs, rls, pv;
    logic [6:0] pk;
    logic [1:0] pp;
    if (rst) begin
      m_reset();
      return;
    end
    acc = key_valid && m_ready();
    prs = acc && key_down;
    rls = acc && !key_down;
    pv = m_pv; pk = m_pk; pp = m_pp;
    if (m_ph != SILENT) begin
      if (prs) begin pv = 1; pk = key_code; pp = key_preset; end
      else if (rls && m_pv && key_code == m_pk) pv = 0;
    end
    case (m_ph)
      SILENT: if (prs) begin m_cur = m_tbl[key_preset]; m_key = key_code; m_ph = LAUNCH; end
      LAUNCH: begin
        if (rls && key_code == m_key) m_early = 1;
        m_ph = ENGAGE;
      end
      ENGAGE: begin
        if (rls && key_code == m_key) m_early = 1;
        if (env_busy) m_ph = SOUND;
      end
      SOUND: if (m_early || m_pv || prs || (rls && key_code == m_key)) begin
        m_early = 0; m_ph = RELEASE;
      end
      RELEASE: m_ph = DECAY;
      default: if (env_done) begin
        if (pv) begin m_cur = m_tbl[pp]; m_key = pk; pv = 0; m_ph = LAUNCH; end
        else m_ph = SILENT;
      end
    endcase
    m_pv = pv; m_pk = pk; m_pp = pp;
    if (cfg_we) begin
      case (cfg_field)
        3'd0: m_tbl[cfg_addr].a = cfg_data[17:0];
        3'd1: m_tbl[cfg_addr].b = cfg_data[17:0];
        3'd2: m_tbl[cfg_addr].c = cfg_data[17:0];
        3'd3: m_tbl[cfg_addr].d = cfg_data[17:0];
        3'd4: m_tbl[cfg_addr].x = cfg_data;
        3'd5: m_tbl[cfg_addr].y = cfg_data;
        3'd6: m_tbl[cfg_addr].z = cfg_data;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("note_on", note_on, m_ph == LAUNCH);
    chk("note_off", note_off, m_ph == RELEASE);
    chk("voice_busy", voice_busy, m_ph != SILENT);
    chk("active_key", active_key, m_key);
    chk("env_shape", {env_a, env_b, env_c, env_d, env_x, env_y, env_z}, m_cur);
  endtask

  // One clock: drive at the falling edge, check outputs at the next one.
  task automatic cyc(input bit v, input bit dn, input int code, input int pre,
                     input bit b, input bit d);
    key_valid = v; key_down = dn; key_code = 7'(code); key_preset = 2'(pre);
    env_busy = b; env_done = d;
    #1;
    chk("key_ready", key_ready, m_ready());
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_outputs();
    cfg_we = 0; rst = 0; key_valid = 0; env_done = 0;
  endtask

  task automatic wcfg(input int addr, input int fld, input int data, input bit b);
    cfg_we = 1; cfg_addr = 2'(addr); cfg_field = 3'(fld); cfg_data = 32'(data);
    cyc(0, 0, 0, 0, b, 0);
  endtask

  task automatic to_held(input int code, input int pre);
    cyc(1, 1, code, pre, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  // From the note_on cycle: engage, release the key and let the envelope finish.
  task automatic finish_note(input int code);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, code, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; key_valid = 0; key_down = 0; key_code = '0; key_preset = '0;
    cfg_we = 0; cfg_addr = '0; cfg_field = '0; cfg_data = '0; env_busy = 0; env_done = 0;
    repeat (2) @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 0;
    chk("rst_ready", key_ready, 1'b1);
    chk("rst_outs", {note_on, note_off, voice_busy, active_key, env_b, env_z}, '0);

    // Scenario 1: program preset 0 and start a note.
    wcfg(0, 0, 0, 0);   wcfg(0, 1, 100, 0); wcfg(0, 2, 60, 0); wcfg(0, 3, 0, 0);
    wcfg(0, 4, 2, 0);   wcfg(0, 5, 3, 0);   wcfg(0, 6, 4, 0);
    wcfg(1, 1, 32'h7_0000 | 200, 0); wcfg(1, 6, 9, 0); wcfg(1, 7, 55, 0);
    cyc(1, 1, 60, 0, 0, 0);
    chk("s1_note_on", note_on, 1'b1);
    chk("s1_env_b", env_b, 18'd100);
    chk("s1_env_x", env_x, 32'd2);
    chk("s1_active", active_key, 7'd60);

    // Scenario 2: single release gives one note_off, then back to idle.
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 60, 0, 1, 0);
    chk("s2_note_off", note_off, 1'b1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s2_single_pulse", note_off, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("s2_idle", voice_busy, 1'b0);

    // Scenario 3: new press while held retriggers on env_done with its preset.
    to_held(60, 0);
    cyc(1, 1, 64, 1, 1, 0);
    chk("s3_note_off", note_off, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("s3_note_on", note_on, 1'b1);
    chk("s3_active", active_key, 7'd64);
    chk("s3_env_b_trunc", env_b, 18'd200 | 18'h3_0000);
    chk("s3_env_z", env_z, 32'd9);
    finish_note(64);

    // Scenario 4a: last press wins; a press offered while the slot hands over stalls.
    to_held(60, 0);
    cyc(1, 1, 64, 1, 1, 0);
    cyc(1, 1, 67, 0, 0, 0);
    key_valid = 1; key_down = 1; key_code = 7'd70; env_done = 1; m_step_guard();
    cyc(1, 1, 70, 0, 0, 1);
    chk("s4_active", active_key, 7'd67);
    chk("s4_env_b", env_b, 18'd100);
    finish_note(67);

    // Scenario 4b: releasing the pending key before env_done leaves nothing to play.
    to_held(60, 0);
    cyc(1, 1, 64, 1, 1, 0);
    cyc(1, 1, 67, 0, 0, 0);
    cyc(1, 0, 67, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("s4b_idle", voice_busy, 1'b0);
    chk("s4b_no_on", note_on, 1'b0);

    // Scenario 5: foreign release ignored; config change waits for the next load.
    to_held(60, 0);
    cyc(1, 0, 50, 0, 1, 0);
    chk("s5_no_off", note_off, 1'b0);
    wcfg(0, 1, 77, 1);
    chk("s5_frozen", env_b, 18'd100);
    cyc(1, 0, 60, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 60, 0, 0, 0);
    chk("s5_new_b", env_b, 18'd77);
    finish_note(60);

    // Scenario 6: reset while held drops the note silently.
    to_held(60, 0);
    rst = 1;
    cyc(0, 0, 0, 0, 1, 0);
    chk("s6_outs", {note_on, note_off, voice_busy, active_key, env_b}, '0);
    cyc(1, 1, 61, 0, 0, 0);
    chk("s6_restart", {note_on, active_key}, {1'b1, 7'd61});

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) begin
        cfg_we = 1; cfg_addr = 2'($urandom); cfg_field = 3'($urandom); cfg_data = $urandom;
      end
      if ($urandom_range(499) == 0) rst = 1;
      cyc($urandom_range(2) == 0, $urandom_range(1) == 1, 60 + $urandom_range(3),
          $urandom_range(3), $urandom_range(3) != 0, $urandom_range(4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Explicit check that a press offered during the hand-over cycle is refused.
  task automatic m_step_guard();
    #1;
    chk("s4_ready_low", key_ready, 1'b0);
  endtask

endmodule
